// File: rtl/bcd_sw_pkg.sv
// Shared constants for the BCD stopwatch: FSM state encoding and BCD digit limits.
package bcd_sw_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_OVF   = 2'd3;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_stopwatch_ctrl_digit.sv
// One BCD digit (0..9) with synchronous clear; carry marks a 9->0 rollover in this cycle.
module bcd_digit_cell
  import bcd_sw_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] q,
  output logic             carry
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      q <= '0;
    end else if (inc) begin
      q <= (q == BCD_MAX) ? '0 : q + 1'b1;
    end
  end

  assign carry = inc & (q == BCD_MAX);

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Stopwatch sequencer: start/pause/clear FSM, tick prescaler and a cascaded BCD counter.
// Optional lap-hold display freeze is enabled by defining LAP_HOLD_EN.
module bcd_stopwatch_ctrl
  import bcd_sw_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 50000,
  parameter int PRE_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_stop,
  input  logic                clear,
  input  logic                lap,
  output logic [4*DIGITS-1:0] digits_out,
  output logic                running,
  output logic                overflow,
  output logic                lap_active,
  output logic [1:0]          fsm_state
);

  logic [1:0]            state;
  logic [PRE_W-1:0]      pre;
  logic [4*DIGITS-1:0]   live;
  logic [DIGITS-1:0]     inc;
  logic [DIGITS-1:0]     carry;
  logic                  tick;
  logic                  all9;
  logic                  ovf_go;

  assign tick   = (state == ST_RUN) && (pre == PRE_W'(TICK_DIV - 1));
  assign ovf_go = tick & all9;

  always_comb begin
    all9 = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (live[i*BCD_W +: BCD_W] != BCD_MAX) all9 = 1'b0;
    end
  end

  // Gating digit 0 at all-9s makes the counter saturate on the overflow tick.
  assign inc[0] = tick & ~all9;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clear),
      .inc   (inc[g]),
      .q     (live[g*BCD_W +: BCD_W]),
      .carry (carry[g])
    );
    if (g < DIGITS - 1) begin : g_link
      assign inc[g+1] = carry[g];
    end
  end

  logic unused_carry;
  assign unused_carry = carry[DIGITS-1];

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state <= ST_IDLE;
      pre   <= '0;
    end else begin
      if (state == ST_RUN) pre <= tick ? '0 : pre + 1'b1;
      case (state)
        ST_IDLE:  if (start_stop) state <= ST_RUN;
        // A tick landing with start_stop still commits; overflow outranks the pause.
        ST_RUN: begin
          if (ovf_go)          state <= ST_OVF;
          else if (start_stop) state <= ST_PAUSE;
        end
        ST_PAUSE: if (start_stop) state <= ST_RUN;
        default:  ;
      endcase
    end
  end

  assign running   = (state == ST_RUN);
  assign overflow  = (state == ST_OVF);
  assign fsm_state = state;

`ifdef LAP_HOLD_EN
  logic [4*DIGITS-1:0] snap;
  logic                lap_ok;

  assign lap_ok = lap && !start_stop &&
                  (((state == ST_RUN) && !ovf_go) || (state == ST_PAUSE));

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      lap_active <= 1'b0;
      snap       <= '0;
    end else if (ovf_go) begin
      lap_active <= 1'b0;
    end else if (lap_ok) begin
      lap_active <= ~lap_active;
      if (!lap_active) snap <= live;
    end
  end

  assign digits_out = lap_active ? snap : live;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign lap_active = 1'b0;
  assign digits_out = live;
`endif

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Self-checking bench for bcd_stopwatch_ctrl (DIGITS=2, TICK_DIV=4) against an integer-count model.
module tb_bcd_stopwatch_ctrl;

  localparam int DIGITS   = 2;
  localparam int TICK_DIV = 4;
  localparam int PRE_W    = 2;
  localparam int MAXC     = 99;
`ifdef LAP_HOLD_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic                clk;
  logic                rst_n;
  logic                start_stop;
  logic                clear;
  logic                lap;
  logic [4*DIGITS-1:0] digits_out;
  logic                running;
  logic                overflow;
  logic                lap_active;
  logic [1:0]          fsm_state;

  bcd_stopwatch_ctrl #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .PRE_W(PRE_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_stop (start_stop),
    .clear      (clear),
    .lap        (lap),
    .digits_out (digits_out),
    .running    (running),
    .overflow   (overflow),
    .lap_active (lap_active),
    .fsm_state  (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model: 0 idle, 1 run, 2 pause, 3 overflow; count is a plain integer
  int m_mode  = 0;
  int m_count = 0;
  int m_pre   = 0;
  int m_snap  = 0;
  bit m_lap   = 1'b0;

  logic [4*DIGITS-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic lap_toggle(input int shown);
    m_lap = !m_lap;
    if (m_lap) m_snap = shown;
  endtask

  task automatic model_edge(input bit ss, input bit cl, input bit lp);
    bit tick;
    int old;
    if (!rst_n || cl) begin
      m_mode = 0; m_count = 0; m_pre = 0; m_snap = 0; m_lap = 1'b0;
      return;
    end
    tick = (m_mode == 1) && (m_pre == TICK_DIV - 1);
    old  = m_count;
    case (m_mode)
      0: if (ss) m_mode = 1;
      1: begin
        m_pre = (m_pre + 1) % TICK_DIV;
        if (tick && m_count == MAXC) begin
          m_mode = 3;
          m_lap  = 1'b0;
        end else begin
          if (tick) m_count++;
          if (ss) m_mode = 2;
          else if (lp && LAP_EN) lap_toggle(old);
        end
      end
      2: begin
        if (ss) m_mode = 1;
        else if (lp && LAP_EN) lap_toggle(old);
      end
      default: ;
    endcase
  endtask

  task automatic compare_outputs();
    logic [4*DIGITS-1:0] e;
    e = exp_q.pop_front();
    check("digits_out", 32'(digits_out), 32'(e));
    check("running",    32'(running),    32'(m_mode == 1));
    check("overflow",   32'(overflow),   32'(m_mode == 3));
    check("lap_active", 32'(lap_active), 32'(m_lap));
    check("fsm_state",  32'(fsm_state),  32'(m_mode));
  endtask

  // driver: inputs set at negedge, model stepped at posedge, outputs sampled 1ns later
  task automatic drive_cycle(input bit ss, input bit cl, input bit lp);
    start_stop = ss;
    clear      = cl;
    lap        = lp;
    @(posedge clk);
    model_edge(ss, cl, lp);
    exp_q.push_back(to_bcd(m_lap ? m_snap : m_count));
    #1;
    compare_outputs();
    @(negedge clk);
    start_stop = 1'b0;
    clear      = 1'b0;
    lap        = 1'b0;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_until(input int target, input int budget);
    int n;
    n = 0;
    while (m_count != target && n < budget) begin
      drive_cycle(1'b0, 1'b0, 1'b0);
      n++;
    end
    check("reach_count", 32'(digits_out), 32'(to_bcd(target)));
  endtask

  initial begin
    rst_n      = 1'b0;
    start_stop = 1'b0;
    clear      = 1'b0;
    lap        = 1'b0;
    @(negedge clk);
    run_cycles(2);
    rst_n = 1'b1;

    // 1: reset mid-count
    drive_cycle(1'b1, 1'b0, 1'b0);
    run_cycles(9);
    rst_n = 1'b0;
    run_cycles(2);
    rst_n = 1'b1;
    run_cycles(1);
    check("t1_digits", 32'(digits_out), 32'h00);
    check("t1_running", 32'(running), 32'h0);
    check("t1_overflow", 32'(overflow), 32'h0);

    // 2: start and run 40 cycles, passing the 09->10 carry
    drive_cycle(1'b1, 1'b0, 1'b0);
    run_cycles(40);
    check("t2_digits", 32'(digits_out), 32'h10);

    // 3: pause mid-prescaler at 23, hold, resume
    run_until(23, 200);
    run_cycles(2);
    drive_cycle(1'b1, 1'b0, 1'b0);
    run_cycles(20);
    check("t3_paused", 32'(digits_out), 32'h23);
    drive_cycle(1'b1, 1'b0, 1'b0);
    check("t3_resume", 32'(digits_out), 32'h23);
    run_cycles(1);
    check("t3_next_inc", 32'(digits_out), 32'h24);

    // 4: overflow saturation
    run_until(99, 400);
    run_cycles(TICK_DIV);
    check("t4_overflow", 32'(overflow), 32'h1);
    check("t4_digits", 32'(digits_out), 32'h99);
    drive_cycle(1'b1, 1'b0, 1'b0);
    run_cycles(3);
    check("t4_ss_ignored", 32'(overflow), 32'h1);
    check("t4_not_running", 32'(running), 32'h0);
    drive_cycle(1'b0, 1'b1, 1'b0);
    check("t4_clear", 32'(digits_out), 32'h00);
    check("t4_idle", 32'(fsm_state), 32'h0);

    // 5: clear and start_stop together during RUN
    drive_cycle(1'b1, 1'b0, 1'b0);
    run_cycles(10);
    drive_cycle(1'b1, 1'b1, 1'b0);
    check("t5_idle", 32'(fsm_state), 32'h0);
    check("t5_digits", 32'(digits_out), 32'h00);
    check("t5_running", 32'(running), 32'h0);

`ifdef LAP_HOLD_EN
    // 6: lap hold freezes display while counting continues
    drive_cycle(1'b1, 1'b0, 1'b0);
    run_until(15, 200);
    drive_cycle(1'b0, 1'b0, 1'b1);
    run_cycles(20);
    check("t6_frozen", 32'(digits_out), 32'h15);
    check("t6_lap_on", 32'(lap_active), 32'h1);
    drive_cycle(1'b0, 1'b0, 1'b1);
    check("t6_release", 32'(digits_out), 32'h20);
    check("t6_lap_off", 32'(lap_active), 32'h0);
    drive_cycle(1'b0, 1'b1, 1'b0);
`endif

    // random phases: busy buttons, then long runs that can reach overflow
    for (int i = 0; i < 1500; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      drive_cycle($urandom_range(0, 9) == 0, $urandom_range(0, 149) == 0,
                  $urandom_range(0, 11) == 0);
      rst_n = 1'b1;
    end
    for (int i = 0; i < 3000; i++) begin
      drive_cycle($urandom_range(0, 399) == 0, $urandom_range(0, 999) == 0,
                  $urandom_range(0, 29) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
